// File: rtl/first_down_counter.sv
// Loadable WIDTH-bit down counter with a one-cycle underflow pulse on the 0 -> all-ones wrap.
// Define FIRST_DOWN_COUNTER_RELOAD_EN to reload the last loaded value on underflow instead of wrapping.
module first_down_counter #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_out,
    output logic             underflow_out,
    output logic             busy_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             underflow_reg, underflow_next;

`ifdef FIRST_DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload_reg, reload_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_reg <= '0;
        end else begin
            reload_reg <= reload_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= RESET_COUNT;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            underflow_reg <= underflow_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        underflow_next = 1'b0;
`ifdef FIRST_DOWN_COUNTER_RELOAD_EN
        reload_next    = reload_reg;
`endif
        case (state_reg)
            IDLE: begin
                // Enable is deliberately ignored until a value has been loaded.
                if (load) begin
                    count_next  = load_value;
`ifdef FIRST_DOWN_COUNTER_RELOAD_EN
                    reload_next = load_value;
`endif
                    state_next  = ARMED;
                end
            end
            ARMED: begin
                if (load) begin
                    count_next  = load_value;
`ifdef FIRST_DOWN_COUNTER_RELOAD_EN
                    reload_next = load_value;
`endif
                end else if (enable) begin
                    if (count_reg == '0) begin
                        underflow_next = 1'b1;
`ifdef FIRST_DOWN_COUNTER_RELOAD_EN
                        count_next     = reload_reg;
`else
                        count_next     = count_reg - WIDTH'(1);
`endif
                    end else begin
                        count_next = count_reg - WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign counter_out   = count_reg;
    assign underflow_out = underflow_reg;
    assign busy_out      = (state_reg == ARMED);

endmodule

// File: tb/tb_first_down_counter.sv
// Directed self-checking bench for first_down_counter (WIDTH=4, RESET_VALUE=0).
// Runs the wrap tests by default, the auto-reload tests when FIRST_DOWN_COUNTER_RELOAD_EN is defined.
module tb_first_down_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] counter_out;
    logic       underflow_out;
    logic       busy_out;

    int tests_run = 0;
    int tests_failed = 0;

    first_down_counter #(
        .WIDTH       (4),
        .RESET_VALUE (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .load          (load),
        .load_value    (load_value),
        .counter_out   (counter_out),
        .underflow_out (underflow_out),
        .busy_out      (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        logic prev_uf;

        reset      = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        load_value = 4'd0;

        // Asynchronous reset between edges (posedges at 5, 15, ...).
        #7 reset = 1'b0;
        #1;
        check("async_rst_count", 32'(counter_out), 32'd0);
        check("async_rst_busy", 32'(busy_out), 32'd0);
        check("async_rst_uf", 32'(underflow_out), 32'd0);

        tick();
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_count", 32'(counter_out), 32'd0);
            check("idle_busy", 32'(busy_out), 32'd0);
        end

        // Load 5 then count down to 0.
        load       = 1'b1;
        load_value = 4'd5;
        enable     = 1'b0;
        tick();
        check("load5_count", 32'(counter_out), 32'd5);
        check("load5_busy", 32'(busy_out), 32'd1);
        check("load5_uf", 32'(underflow_out), 32'd0);
        load   = 1'b0;
        enable = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            tick();
            check("dec_count", 32'(counter_out), 32'(i));
            check("dec_uf", 32'(underflow_out), 32'd0);
        end

`ifndef FIRST_DOWN_COUNTER_RELOAD_EN
        tick();
        check("wrap_count", 32'(counter_out), 32'd15);
        check("wrap_uf", 32'(underflow_out), 32'd1);
        tick();
        check("post_wrap_count", 32'(counter_out), 32'd14);
        check("post_wrap_uf", 32'(underflow_out), 32'd0);
        pulses  = 0;
        prev_uf = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (underflow_out === 1'b1) pulses++;
            if (prev_uf === 1'b1) check("uf_not_double", 32'(underflow_out), 32'd0);
            prev_uf = underflow_out;
        end
        check("wrap16_pulses", 32'(pulses), 32'd1);
        check("wrap16_count", 32'(counter_out), 32'd14);
`else
        tick();
        check("reload5_count", 32'(counter_out), 32'd5);
        check("reload5_uf", 32'(underflow_out), 32'd1);
        tick();
        check("reload5_next", 32'(counter_out), 32'd4);
        check("reload5_next_uf", 32'(underflow_out), 32'd0);
`endif

        // Load has priority over enable.
        load       = 1'b1;
        load_value = 4'd9;
        enable     = 1'b0;
        tick();
        check("load9_count", 32'(counter_out), 32'd9);
        load_value = 4'd3;
        enable     = 1'b1;
        tick();
        check("load_prio_count", 32'(counter_out), 32'd3);
        load   = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_count", 32'(counter_out), 32'd3);
            check("hold_uf", 32'(underflow_out), 32'd0);
        end

        // Reset just before the edge that would have wrapped.
        load       = 1'b1;
        load_value = 4'd0;
        tick();
        check("load0_count", 32'(counter_out), 32'd0);
        load   = 1'b0;
        enable = 1'b1;
        #7 reset = 1'b0;
        #1;
        check("midrst_count", 32'(counter_out), 32'd0);
        check("midrst_busy", 32'(busy_out), 32'd0);
        tick();
        check("midrst_edge_uf", 32'(underflow_out), 32'd0);
        check("midrst_edge_count", 32'(counter_out), 32'd0);
        check("midrst_edge_busy", 32'(busy_out), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("postrst_count", 32'(counter_out), 32'd0);
            check("postrst_busy", 32'(busy_out), 32'd0);
            check("postrst_uf", 32'(underflow_out), 32'd0);
        end

`ifdef FIRST_DOWN_COUNTER_RELOAD_EN
        // Auto-reload: 2,1,0,2,1,0 with a pulse on each 0 -> 2.
        load       = 1'b1;
        load_value = 4'd2;
        enable     = 1'b0;
        tick();
        check("ar_load_count", 32'(counter_out), 32'd2);
        load   = 1'b0;
        enable = 1'b1;
        begin
            logic [3:0] exp_seq [6];
            logic       exp_uf  [6];
            exp_seq = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
            exp_uf  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 6; i++) begin
                tick();
                check("ar_count", 32'(counter_out), 32'(exp_seq[i]));
                check("ar_uf", 32'(underflow_out), 32'(exp_uf[i]));
            end
        end
        load       = 1'b1;
        load_value = 4'd0;
        enable     = 1'b0;
        tick();
        check("ar_load0_count", 32'(counter_out), 32'd0);
        load   = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_zero_count", 32'(counter_out), 32'd0);
            check("ar_zero_uf", 32'(underflow_out), 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/first_down_counter.md
Name: first_down_counter

Overview:
- Loadable WIDTH-bit down counter; the counting-direction counterpart of the existing up counter with overflow.
- Holds in IDLE until a value is loaded, then decrements on enable.
- Flags a one-cycle underflow_out pulse on the 0 -> all-ones wrap.
- Used as a countdown/timeout source alongside first_counter and shares its clk/reset/enable conventions.

Parameters:
- WIDTH, 4: counter width in bits.
- RESET_VALUE, 0: value of counter_out after reset. Must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. reset=0 resets immediately, independent of clk.
- enable  input  1  decrement request, sampled on rising clk.
- load  input  1  load request, sampled on rising clk. Has priority over enable.
- load_value  input  WIDTH  value captured when load=1.
- counter_out  output  WIDTH  current count, registered.
- underflow_out  output  1  registered pulse, high for exactly one cycle after a 0 -> 2^WIDTH-1 wrap.
- busy_out  output  1  high while state is ARMED.

Behaviour:
- Reset (reset=0, asynchronous assert):
  - counter_out=RESET_VALUE, underflow_out=0, busy_out=0, state=IDLE, internal reload register=0.
  - Release is sampled synchronously: the first active edge is the first rising clk with reset=1.
- States: IDLE, ARMED. busy_out equals (state==ARMED) and is registered with the state.
- IDLE:
  - load=1: counter_out<=load_value, reload register<=load_value, state<=ARMED.
  - enable is ignored; counter_out holds.
- ARMED:
  - load=1: counter_out<=load_value, reload register updated, underflow_out<=0. Stays ARMED, even if enable=1 in the same cycle.
  - load=0, enable=1: counter_out<=counter_out-1, modulo 2^WIDTH.
    - If counter_out was 0 on this edge, underflow_out<=1 for exactly the next cycle; otherwise underflow_out<=0.
  - load=0, enable=0: counter_out holds, underflow_out<=0.
- Latency:
  - Load and decrement are visible on counter_out one clock after the sampling edge.
  - underflow_out rises on the same edge that counter_out becomes 2^WIDTH-1.
- Consecutive wraps: with enable held for 2^WIDTH cycles, underflow_out pulses once per 2^WIDTH decrements. It never stays high for 2 consecutive cycles.
- ARMED -> IDLE occurs only through reset. There is no software disarm.
- Reset mid-count: all outputs go to their reset values immediately, asynchronously. A pending underflow pulse is cancelled.
- Arithmetic is unsigned, WIDTH bits, and wraps. There is no saturation.

Optional Feature:
- Macro: FIRST_DOWN_COUNTER_RELOAD_EN.
- Defined (auto-reload): on a decrement from 0, counter_out<=reload register instead of 2^WIDTH-1. underflow_out still pulses for one cycle.
  - If the reload register is 0, the counter stays at 0 and pulses underflow_out on every enabled cycle.
- Undefined: plain wrap to 2^WIDTH-1. The reload register is not implemented.

Test Plan:
- Reset behaviour: reset=0 mid-cycle at t=7 with no clock edge -> counter_out=0, busy_out=0, underflow_out=0 immediately. Hold reset=1 with enable=1 and no load for 5 cycles -> counter_out stays 0 and busy_out stays 0 (IDLE ignores enable).
- Load then count: load=1, load_value=5 for 1 cycle, then enable=1 for 5 cycles -> busy_out=1; counter_out follows 5,4,3,2,1,0; underflow_out=0 throughout.
- Underflow wrap (macro undefined): continue enable=1 from 0 -> counter_out=15 and underflow_out=1 for exactly one cycle. Next cycle counter_out=14, underflow_out=0. Hold enable for 16 more cycles -> exactly one more pulse.
- Load priority: at counter_out=9, assert load=1, load_value=3 with enable=1 -> counter_out=3 next cycle, not 8. Enable=0 for 4 cycles -> holds at 3.
- Reset mid-operation: at counter_out=0 with enable=1, assert reset=0 just before the clk edge -> underflow_out stays 0, counter_out=0, busy_out=0. After release, enable alone does not change counter_out.
- Auto-reload (macro defined): load 2, enable continuously -> counter_out follows 2,1,0,2,1,0; underflow_out pulses on each 0 -> 2 transition. Load 0, then enable -> counter_out stays 0 and underflow_out=1 on every enabled cycle.
